uart_rx_param: RTL and testbench

Parametrised successor to the team's fixed 8N1 UART receiver.
- Frame format is configurable: data width, parity mode, stop-bit count and oversampling ratio.
- Adds input synchronisation, glitch-rejecting start detection, parity/framing/overrun error reporting and a valid/ready output handshake.
- Sits between the board RX pin and the SoC's MMIO UART or a consumer FIFO.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_baud_tick.sv | 29 ++
 rtl/uart_rx_param.sv | 186 ++++++++++++++++++
 tb/tb_uart_rx_param.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART blocks.
// FSM state encoding, parity mode codes and the baud tick divider.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  function automatic int tick_div(
    input int f_clk,
    input int baud,
    input int os
  );
    return f_clk / (os * baud);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick divider: one-cycle tick every DIV clocks.
// clear holds the count at 0 so the next tick is phase-aligned.
module uart_baud_tick #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  assign tick = (cnt == LAST) && !clear;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with valid/ready output and error flags.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority voting per bit.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int F_CLK      = 1_000_000,
  parameter int BAUDRATE   = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int TICK_DIV = tick_div(F_CLK, BAUDRATE, OVERSAMPLE);
  localparam int PW = $clog2(OVERSAMPLE);
  localparam logic [PW-1:0] PH_LAST = PW'(OVERSAMPLE - 1);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [PW-1:0] PH_SMP = PW'(OVERSAMPLE / 2);
`else
  localparam logic [PW-1:0] PH_SMP = PW'(OVERSAMPLE / 2 - 1);
`endif
  localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic ODD = (PARITY == PARITY_ODD);

  if (TICK_DIV < 1 || OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0 ||
      DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_cfg
    $error("uart_rx_param: illegal configuration");
  end

  state_t               state;
  logic [1:0]           sync;
  logic                 rx_s;
  logic                 tick;
  logic                 clear;
  logic                 bit_v;
  logic                 samp;
  logic                 accept;
  logic                 par_bad;
  logic [PW-1:0]        ph;
  logic [3:0]           bcnt;
  logic [DATA_BITS-1:0] sreg;
  logic                 perr;
  logic                 ferr;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], rx};
    end
  end

  assign rx_s = sync[1];
  assign clear = (state == ST_IDLE);

  uart_baud_tick #(
    .DIV(TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clear(clear),
    .tick (tick)
  );

`ifdef UART_RX_MAJORITY_EN
  // hist holds the samples one and two ticks before the voting tick
  logic [1:0] hist;

  always_ff @(posedge clk) begin
    if (rst) begin
      hist <= 2'b11;
    end else if (tick) begin
      hist <= {hist[0], rx_s};
    end
  end

  assign bit_v = (hist[1] & hist[0]) |
                 (hist[1] & rx_s) |
                 (hist[0] & rx_s);
`else
  assign bit_v = rx_s;
`endif

  assign samp    = tick && (ph == PH_SMP);
  assign accept  = !rx_valid || rx_ready;
  assign par_bad = ((^sreg) ^ bit_v) != ODD;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      ph          <= '0;
      bcnt        <= '0;
      sreg        <= '0;
      perr        <= 1'b0;
      ferr        <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      overrun_err <= 1'b0;
      busy        <= (state != ST_IDLE);
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      if (tick) begin
        ph <= (ph == PH_LAST) ? '0 : ph + 1'b1;
      end
      unique case (state)
        ST_IDLE: begin
          ph   <= '0;
          bcnt <= '0;
          if (!rx_s) begin
            state <= ST_START;
          end
        end
        ST_START: begin
          if (samp) begin
            if (bit_v) begin
              state <= ST_IDLE;
            end else begin
              state <= ST_DATA;
              perr  <= 1'b0;
              ferr  <= 1'b0;
            end
          end
        end
        ST_DATA: begin
          if (samp) begin
            sreg <= {bit_v, sreg[DATA_BITS-1:1]};
            if (bcnt == DATA_LAST) begin
              bcnt  <= '0;
              state <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              bcnt <= bcnt + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (samp) begin
            perr  <= par_bad;
            state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (samp) begin
            if (bcnt == STOP_LAST) begin
              state <= ST_IDLE;
              bcnt  <= '0;
              if (accept) begin
                rx_data    <= sreg;
                parity_err <= perr;
                frame_err  <= ferr | !bit_v;
                rx_valid   <= 1'b1;
              end else begin
                overrun_err <= 1'b1;
              end
            end else begin
              bcnt <= bcnt + 1'b1;
              if (!bit_v) begin
                ferr <= 1'b1;
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: 8N1, 8E1 and 7O2 instances at 64 clk/bit.
// Vector table plus scoreboard, with overrun, glitch and reset sequences.
module tb_uart_rx_param;

  localparam int FCLK = 7_372_800;
  localparam int BAUD = 115200;
  localparam int BIT  = 64;

  typedef struct {
    int         k;
    logic [8:0] data;
    logic       pbit;
    logic [1:0] stop0;
    logic [8:0] exp_d;
    logic       exp_pe;
    logic       exp_fe;
  } vec_t;

  typedef struct {
    int         k;
    logic [8:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ready = 1'b1;
  logic [2:0] rx = 3'b111;

  logic [7:0] d0;
  logic [7:0] d1;
  logic [6:0] d2;
  logic [2:0] v;
  logic [2:0] pe;
  logic [2:0] fe;
  logic [2:0] ov;
  logic [2:0] bz;
  logic [8:0] dw [3];

  exp_t sb[$];
  vec_t vecs[11];
  int   errors = 0;
  int   checks = 0;
  int   vcnt[3] = '{0, 0, 0};
  int   ovcnt[3] = '{0, 0, 0};

  always #5 clk = ~clk;

  assign dw[0] = {1'b0, d0};
  assign dw[1] = {1'b0, d1};
  assign dw[2] = {2'b00, d2};

  uart_rx_param #(
    .F_CLK(FCLK), .BAUDRATE(BAUD), .OVERSAMPLE(16),
    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
  ) dut_n (
    .clk(clk), .rst(rst), .rx(rx[0]),
    .rx_data(d0), .rx_valid(v[0]), .rx_ready(ready),
    .parity_err(pe[0]), .frame_err(fe[0]),
    .overrun_err(ov[0]), .busy(bz[0])
  );

  uart_rx_param #(
    .F_CLK(FCLK), .BAUDRATE(BAUD), .OVERSAMPLE(16),
    .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)
  ) dut_e (
    .clk(clk), .rst(rst), .rx(rx[1]),
    .rx_data(d1), .rx_valid(v[1]), .rx_ready(ready),
    .parity_err(pe[1]), .frame_err(fe[1]),
    .overrun_err(ov[1]), .busy(bz[1])
  );

  uart_rx_param #(
    .F_CLK(FCLK), .BAUDRATE(BAUD), .OVERSAMPLE(16),
    .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)
  ) dut_o (
    .clk(clk), .rst(rst), .rx(rx[2]),
    .rx_data(d2), .rx_valid(v[2]), .rx_ready(ready),
    .parity_err(pe[2]), .frame_err(fe[2]),
    .overrun_err(ov[2]), .busy(bz[2])
  );

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k, input logic b);
    rx[k] = b;
    cyc(BIT);
  endtask

  task automatic send(input int k, input logic [8:0] d,
                      input logic pbit, input logic [1:0] stop0);
    int nb;
    int ns;
    nb = (k == 2) ? 7 : 8;
    ns = (k == 2) ? 2 : 1;
    drive(k, 1'b0);
    for (int i = 0; i < nb; i++) drive(k, d[i]);
    if (k != 0) drive(k, pbit);
    for (int s = 0; s < ns; s++) drive(k, ~stop0[s]);
    rx[k] = 1'b1;
    cyc(2 * BIT);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        if (v[k]) vcnt[k]++;
        if (ov[k]) ovcnt[k]++;
        if (v[k] && ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word dut%0d: got %0h expected none",
                     k, dw[k]);
          end else begin
            e = sb.pop_front();
            chk($sformatf("word_dut%0d_%0h", e.k, e.d),
                {2'(k), dw[k], pe[k], fe[k]},
                {2'(e.k), e.d, e.pe, e.fe});
          end
        end
      end
    end
  end

  initial begin
    int b;
    int w;
    vecs[0]  = '{0, 9'hA5, 1'b0, 2'b00, 9'hA5, 1'b0, 1'b0};
    vecs[1]  = '{1, 9'h03, 1'b1, 2'b00, 9'h03, 1'b1, 1'b0};
    vecs[2]  = '{1, 9'h03, 1'b0, 2'b00, 9'h03, 1'b0, 1'b0};
    vecs[3]  = '{0, 9'h55, 1'b0, 2'b01, 9'h55, 1'b0, 1'b1};
    vecs[4]  = '{0, 9'h12, 1'b0, 2'b00, 9'h12, 1'b0, 1'b0};
    vecs[5]  = '{2, 9'h5A, 1'b1, 2'b00, 9'h5A, 1'b0, 1'b0};
    vecs[6]  = '{2, 9'h5A, 1'b0, 2'b00, 9'h5A, 1'b1, 1'b0};
    vecs[7]  = '{2, 9'h2B, 1'b1, 2'b10, 9'h2B, 1'b0, 1'b1};
    vecs[8]  = '{1, 9'h80, 1'b0, 2'b00, 9'h80, 1'b1, 1'b0};
    vecs[9]  = '{0, 9'h00, 1'b0, 2'b00, 9'h00, 1'b0, 1'b0};
    vecs[10] = '{0, 9'hFF, 1'b0, 2'b00, 9'hFF, 1'b0, 1'b0};

    cyc(3);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset_flags_dut%0d", k),
          {v[k], pe[k], fe[k], ov[k], bz[k]}, 0);
      chk($sformatf("reset_data_dut%0d", k), dw[k], 0);
    end
    rst = 1'b0;
    cyc(4);

    foreach (vecs[i]) begin
      b = vcnt[vecs[i].k];
      sb.push_back('{vecs[i].k, vecs[i].exp_d,
                     vecs[i].exp_pe, vecs[i].exp_fe});
      send(vecs[i].k, vecs[i].data, vecs[i].pbit, vecs[i].stop0);
      chk($sformatf("valid_cycles_vec%0d", i), vcnt[vecs[i].k] - b, 1);
    end

    // two frames with no consumer: second is dropped as an overrun
    ready = 1'b0;
    b = ovcnt[0];
    sb.push_back('{0, 9'h11, 1'b0, 1'b0});
    send(0, 9'h11, 1'b0, 2'b00);
    send(0, 9'h22, 1'b0, 2'b00);
    chk("overrun_valid_held", v[0], 1);
    chk("overrun_data_kept", d0, 8'h11);
    chk("overrun_pulses", ovcnt[0] - b, 1);
    ready = 1'b1;
    cyc(2);
    chk("valid_drop_after_accept", v[0], 0);

    // 20-clk glitch on idle line
    b = vcnt[0];
    rx[0] = 1'b0;
    cyc(20);
    rx[0] = 1'b1;
    cyc(5);
    chk("glitch_busy_high", bz[0], 1);
    w = 0;
    while (bz[0] && w < 40) begin
      cyc(1);
      w++;
    end
    chk("glitch_busy_low_in_time", bz[0], 0);
    cyc(4 * BIT);
    chk("glitch_no_valid", vcnt[0] - b, 0);

    // reset in the middle of the data bits of 0xFF
    rx[0] = 1'b0;
    cyc(BIT);
    rx[0] = 1'b1;
    cyc(3 * BIT);
    rst = 1'b1;
    cyc(2);
    chk("midreset_busy", bz[0], 0);
    chk("midreset_valid", v[0], 0);
    rst = 1'b0;
    cyc(8 * BIT);
    b = vcnt[0];
    sb.push_back('{0, 9'h3C, 1'b0, 1'b0});
    send(0, 9'h3C, 1'b0, 2'b00);
    chk("after_reset_single_word", vcnt[0] - b, 1);

    w = 0;
    while (sb.size() != 0 && w < 2000) begin
      cyc(1);
      w++;
    end
    chk("scoreboard_drained", sb.size(), 0);
    chk("total_overruns_n", ovcnt[0], 1);
    chk("total_overruns_eo", ovcnt[1] + ovcnt[2], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
